// File: rtl/pu_riscv_rf_pkg.sv
// Shared types and constants for the multi-port RISC-V register file.
package pu_riscv_rf_pkg;

    // Clear sequencer states
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Width of the debug-unit address bus
    localparam int unsigned DU_ADDR_W = 12;

endpackage : pu_riscv_rf_pkg

// File: rtl/pu_riscv_rf_mp_if.sv
// Register-file access bus: pipeline read/write ports, busy flag and debug port.
interface pu_riscv_rf_mp_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned AR_BITS = 5,
    parameter int unsigned RDPORTS = 2,
    parameter int unsigned WRPORTS = 2
);
    import pu_riscv_rf_pkg::*;

    logic [RDPORTS-1:0][AR_BITS-1:0] rf_src1;
    logic [RDPORTS-1:0][AR_BITS-1:0] rf_src2;
    logic [RDPORTS-1:0][XLEN-1:0]    rf_srcv1;
    logic [RDPORTS-1:0][XLEN-1:0]    rf_srcv2;
    logic [WRPORTS-1:0][AR_BITS-1:0] rf_dst;
    logic [WRPORTS-1:0][XLEN-1:0]    rf_dstv;
    logic [WRPORTS-1:0]              rf_we;
    logic                            rf_busy;
    logic                            du_stall;
    logic                            du_we_rf;
    logic                            du_re_rf;
    logic [DU_ADDR_W-1:0]            du_addr;
    logic [XLEN-1:0]                 du_dato;
    logic [XLEN-1:0]                 du_dati_rf;
    logic                            du_ack;

    modport slave (
        input  rf_src1, rf_src2, rf_dst, rf_dstv, rf_we,
        input  du_stall, du_we_rf, du_re_rf, du_addr, du_dato,
        output rf_srcv1, rf_srcv2, rf_busy, du_dati_rf, du_ack
    );

    modport master (
        output rf_src1, rf_src2, rf_dst, rf_dstv, rf_we,
        output du_stall, du_we_rf, du_re_rf, du_addr, du_dato,
        input  rf_srcv1, rf_srcv2, rf_busy, du_dati_rf, du_ack
    );

endinterface : pu_riscv_rf_mp_if

// File: rtl/pu_riscv_rf_clr.sv
// Post-reset clear sequencer: walks every register-file entry once, writing zero.
module pu_riscv_rf_clr
    import pu_riscv_rf_pkg::*;
#(
    parameter int unsigned AR_BITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    output logic               busy_o,
    output logic [AR_BITS-1:0] clr_addr_o,
    output logic               clr_en_o
);

    localparam logic [AR_BITS-1:0] CNT_MAX = {AR_BITS{1'b1}};

    rf_state_e          state_q;
    logic [AR_BITS-1:0] cnt_q;

    // Sequencer: clear one entry per cycle, then park in READY until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AR_BITS'(1);
                    end
                end
                READY:   state_q <= READY;
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign busy_o     = (state_q == CLEAR);
    assign clr_en_o   = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;

endmodule : pu_riscv_rf_clr

// File: rtl/pu_riscv_rf_mp.sv
// Multi-port RISC-V integer register file with registered reads, optional
// write-to-read bypass, self-clearing after reset and a debug access port.
module pu_riscv_rf_mp
    import pu_riscv_rf_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned AR_BITS = 5,
    parameter int unsigned RDPORTS = 2,
    parameter int unsigned WRPORTS = 2,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pu_riscv_rf_mp_if.slave       rf_if
);

    localparam int unsigned DEPTH = 2 ** AR_BITS;

    logic [XLEN-1:0]    mem_q [DEPTH];
    logic [XLEN-1:0]    mem_d [DEPTH];

    logic               clr_busy;
    logic               clr_en;
    logic [AR_BITS-1:0] clr_addr;

    logic               dbg_ok;
    logic               dbg_we;
    logic               dbg_re;
    logic [AR_BITS-1:0] dbg_addr;
    logic               du_addr_unused;

    logic [RDPORTS-1:0][XLEN-1:0] srcv1_d, srcv1_q;
    logic [RDPORTS-1:0][XLEN-1:0] srcv2_d, srcv2_q;
    logic [XLEN-1:0]              du_dati_d, du_dati_q;
    logic                         du_ack_d, du_ack_q;

    pu_riscv_rf_clr #(
        .AR_BITS    (AR_BITS)
    ) u_clr (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (clr_busy),
        .clr_addr_o (clr_addr),
        .clr_en_o   (clr_en)
    );

    // Debug requests are only honoured while the core is stalled and the file is ready
    always_comb begin
        dbg_ok   = rf_if.du_stall && !clr_busy;
        dbg_we   = dbg_ok && rf_if.du_we_rf;
        dbg_re   = dbg_ok && rf_if.du_re_rf;
        dbg_addr = rf_if.du_addr[AR_BITS-1:0];
    end

    assign du_addr_unused = ^rf_if.du_addr[DU_ADDR_W-1:AR_BITS];

    // Write merge: clear overrides everything; otherwise higher ports win, debug last
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else begin
            for (int w = 0; w < int'(WRPORTS); w++) begin
                if (rf_if.rf_we[w] && (rf_if.rf_dst[w] != '0)) begin
                    mem_d[rf_if.rf_dst[w]] = rf_if.rf_dstv[w];
                end
            end
            if (dbg_we && (dbg_addr != '0)) begin
                mem_d[dbg_addr] = rf_if.du_dato;
            end
        end
    end

    // Storage array; entries are zeroed by the clear sequencer rather than reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read-port selection: forwarded (merged) or pre-write contents, x0 and CLEAR read zero
    always_comb begin
        srcv1_d = '0;
        srcv2_d = '0;
        for (int r = 0; r < int'(RDPORTS); r++) begin
            if (!clr_busy && (rf_if.rf_src1[r] != '0)) begin
                srcv1_d[r] = (BYPASS != 0) ? mem_d[rf_if.rf_src1[r]] : mem_q[rf_if.rf_src1[r]];
            end
            if (!clr_busy && (rf_if.rf_src2[r] != '0)) begin
                srcv2_d[r] = (BYPASS != 0) ? mem_d[rf_if.rf_src2[r]] : mem_q[rf_if.rf_src2[r]];
            end
        end
    end

    // Debug response: read sees this cycle's write; data holds until the next accepted read
    always_comb begin
        du_dati_d = du_dati_q;
        du_ack_d  = dbg_we || dbg_re;
        if (dbg_re) begin
            du_dati_d = (dbg_addr == '0) ? '0 : mem_d[dbg_addr];
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            srcv1_q   <= '0;
            srcv2_q   <= '0;
            du_dati_q <= '0;
            du_ack_q  <= 1'b0;
        end else begin
            srcv1_q   <= srcv1_d;
            srcv2_q   <= srcv2_d;
            du_dati_q <= du_dati_d;
            du_ack_q  <= du_ack_d;
        end
    end

    assign rf_if.rf_srcv1   = srcv1_q;
    assign rf_if.rf_srcv2   = srcv2_q;
    assign rf_if.rf_busy    = clr_busy;
    assign rf_if.du_dati_rf = du_dati_q;
    assign rf_if.du_ack     = du_ack_q;

endmodule : pu_riscv_rf_mp

// File: tb/tb_pu_riscv_rf_mp.sv
// Scoreboard bench for pu_riscv_rf_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_pu_riscv_rf_mp;
    import pu_riscv_rf_pkg::*;

    localparam int K_SRCV1  = 0;
    localparam int K_SRCV2  = 1;
    localparam int K_BUSY   = 2;
    localparam int K_DATI   = 3;
    localparam int K_ACK    = 4;
    localparam int K_SRCV1B = 5;
    localparam int K_SRCV2B = 6;

    typedef struct {
        int          due;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pu_riscv_rf_mp_if #(.XLEN(64), .AR_BITS(5), .RDPORTS(2), .WRPORTS(2)) rf_a ();
    pu_riscv_rf_mp_if #(.XLEN(64), .AR_BITS(5), .RDPORTS(2), .WRPORTS(2)) rf_b ();

    pu_riscv_rf_mp #(.XLEN(64), .AR_BITS(5), .RDPORTS(2), .WRPORTS(2), .BYPASS(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .rf_if (rf_a.slave)
    );

    pu_riscv_rf_mp #(.XLEN(64), .AR_BITS(5), .RDPORTS(2), .WRPORTS(2), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .rst   (rst),
        .rf_if (rf_b.slave)
    );

    assign rf_b.rf_src1  = rf_a.rf_src1;
    assign rf_b.rf_src2  = rf_a.rf_src2;
    assign rf_b.rf_dst   = rf_a.rf_dst;
    assign rf_b.rf_dstv  = rf_a.rf_dstv;
    assign rf_b.rf_we    = rf_a.rf_we;
    assign rf_b.du_stall = rf_a.du_stall;
    assign rf_b.du_we_rf = rf_a.du_we_rf;
    assign rf_b.du_re_rf = rf_a.du_re_rf;
    assign rf_b.du_addr  = rf_a.du_addr;
    assign rf_b.du_dato  = rf_a.du_dato;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int due, int kind, int port, logic [63:0] e, string nm);
        exp_t x;
        x.due = due; x.kind = kind; x.port = port; x.exp = e; x.name = nm;
        sb.push_back(x);
    endfunction

    // Monitor: compare every expectation due on this cycle's outputs
    always @(negedge clk) begin
        logic [63:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_SRCV1:  act = rf_a.rf_srcv1[sb[i].port];
                    K_SRCV2:  act = rf_a.rf_srcv2[sb[i].port];
                    K_BUSY:   act = 64'(rf_a.rf_busy);
                    K_DATI:   act = rf_a.du_dati_rf;
                    K_ACK:    act = 64'(rf_a.du_ack);
                    K_SRCV1B: act = rf_b.rf_srcv1[sb[i].port];
                    default:  act = rf_b.rf_srcv2[sb[i].port];
                endcase
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_a.rf_src1   = '0;
        rf_a.rf_src2   = '0;
        rf_a.rf_dst    = '0;
        rf_a.rf_dstv   = '0;
        rf_a.rf_we     = '0;
        rf_a.du_stall  = 1'b0;
        rf_a.du_we_rf  = 1'b0;
        rf_a.du_re_rf  = 1'b0;
        rf_a.du_addr   = '0;
        rf_a.du_dato   = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset: busy for exactly 32 cycles, outputs zero
        step();
        expect_at(cyc, K_BUSY, 0, 64'd1, "busy_after_rst");
        expect_at(cyc, K_SRCV1, 0, 64'd0, "srcv1_after_rst");
        expect_at(cyc, K_DATI, 0, 64'd0, "dati_after_rst");
        expect_at(cyc, K_ACK, 0, 64'd0, "ack_after_rst");
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            expect_at(cyc, K_BUSY, 0, (k < 32) ? 64'd1 : 64'd0, "busy_clear_seq");
        end

        // Every entry reads zero after clear
        for (int a = 0; a < 32; a++) begin
            rf_a.rf_src1[0] = 5'(a);
            rf_a.rf_src2[1] = 5'(a);
            expect_at(cyc + 1, K_SRCV1, 0, 64'd0, "post_clear_src1");
            expect_at(cyc + 1, K_SRCV2, 1, 64'd0, "post_clear_src2");
            step();
        end
        idle();

        // Bypass: write r5 while reading it
        rf_a.rf_we[0]   = 1'b1;
        rf_a.rf_dst[0]  = 5'd5;
        rf_a.rf_dstv[0] = 64'hDEAD;
        rf_a.rf_src1[0] = 5'd5;
        expect_at(cyc + 1, K_SRCV1, 0, 64'hDEAD, "bypass_on");
        expect_at(cyc + 1, K_SRCV1B, 0, 64'd0, "bypass_off_old");
        step();
        idle();
        rf_a.rf_src2[1] = 5'd5;
        expect_at(cyc + 1, K_SRCV2, 1, 64'hDEAD, "r5_readback");
        expect_at(cyc + 1, K_SRCV2B, 1, 64'hDEAD, "r5_readback_nb");
        step();
        idle();

        // Write-port conflict: port 1 wins, bypass forwards the winner
        rf_a.rf_we      = 2'b11;
        rf_a.rf_dst[0]  = 5'd7;
        rf_a.rf_dstv[0] = 64'h11;
        rf_a.rf_dst[1]  = 5'd7;
        rf_a.rf_dstv[1] = 64'h22;
        rf_a.rf_src2[0] = 5'd7;
        expect_at(cyc + 1, K_SRCV2, 0, 64'h22, "conflict_bypass");
        expect_at(cyc + 1, K_SRCV2B, 0, 64'd0, "conflict_nobypass");
        step();
        idle();
        rf_a.rf_src1[1] = 5'd7;
        expect_at(cyc + 1, K_SRCV1, 1, 64'h22, "conflict_readback");
        expect_at(cyc + 1, K_SRCV1B, 1, 64'h22, "conflict_readback_nb");
        step();
        idle();

        // x0 is hardwired to zero
        rf_a.rf_we[0]   = 1'b1;
        rf_a.rf_dst[0]  = 5'd0;
        rf_a.rf_dstv[0] = 64'hFF;
        expect_at(cyc + 1, K_SRCV1, 0, 64'd0, "x0_bypass_src1");
        expect_at(cyc + 1, K_SRCV2, 0, 64'd0, "x0_bypass_src2");
        step();
        idle();
        expect_at(cyc + 1, K_SRCV1, 0, 64'd0, "x0_src1");
        expect_at(cyc + 1, K_SRCV2, 0, 64'd0, "x0_src2");
        step();

        // Debug write beats pipeline write to the same register
        rf_a.du_stall   = 1'b1;
        rf_a.du_we_rf   = 1'b1;
        rf_a.du_addr    = 12'd3;
        rf_a.du_dato    = 64'hAB;
        rf_a.rf_we[1]   = 1'b1;
        rf_a.rf_dst[1]  = 5'd3;
        rf_a.rf_dstv[1] = 64'hCD;
        rf_a.rf_src1[0] = 5'd3;
        expect_at(cyc + 1, K_SRCV1, 0, 64'hAB, "dbg_we_forward");
        expect_at(cyc + 1, K_ACK, 0, 64'd1, "dbg_we_ack");
        step();
        idle();
        rf_a.du_stall   = 1'b1;
        rf_a.du_re_rf   = 1'b1;
        rf_a.du_addr    = 12'd3;
        rf_a.rf_src2[1] = 5'd3;
        expect_at(cyc + 1, K_SRCV2, 1, 64'hAB, "dbg_reg3");
        expect_at(cyc + 1, K_DATI, 0, 64'hAB, "dbg_re_data");
        expect_at(cyc + 1, K_ACK, 0, 64'd1, "dbg_re_ack");
        step();
        idle();
        expect_at(cyc + 1, K_ACK, 0, 64'd0, "dbg_ack_one_cycle");
        expect_at(cyc + 1, K_DATI, 0, 64'hAB, "dbg_dati_hold");
        step();

        // Unstalled debug read is ignored
        rf_a.du_re_rf = 1'b1;
        rf_a.du_addr  = 12'd7;
        expect_at(cyc + 1, K_ACK, 0, 64'd0, "dbg_nostall_noack");
        expect_at(cyc + 1, K_DATI, 0, 64'hAB, "dbg_nostall_hold");
        step();
        idle();

        // Combined debug write+read returns the written value
        rf_a.du_stall = 1'b1;
        rf_a.du_we_rf = 1'b1;
        rf_a.du_re_rf = 1'b1;
        rf_a.du_addr  = 12'd9;
        rf_a.du_dato  = 64'h1234;
        expect_at(cyc + 1, K_DATI, 0, 64'h1234, "dbg_raw_data");
        expect_at(cyc + 1, K_ACK, 0, 64'd1, "dbg_raw_ack");
        step();
        idle();

        // Debug read of x0
        rf_a.du_stall = 1'b1;
        rf_a.du_re_rf = 1'b1;
        rf_a.du_addr  = 12'd0;
        expect_at(cyc + 1, K_DATI, 0, 64'd0, "dbg_x0_data");
        expect_at(cyc + 1, K_ACK, 0, 64'd1, "dbg_x0_ack");
        step();
        idle();

        // Reset with a debug read in flight: data and ack dropped
        rf_a.du_stall = 1'b1;
        rf_a.du_re_rf = 1'b1;
        rf_a.du_addr  = 12'd9;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        expect_at(cyc, K_DATI, 0, 64'd0, "rst_drop_dati");
        expect_at(cyc, K_ACK, 0, 64'd0, "rst_drop_ack");
        expect_at(cyc, K_BUSY, 0, 64'd1, "rst_busy");
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_at(cyc, K_BUSY, 0, 64'd1, "busy_first_clear");
        end

        // Mid-clear reset restarts the sequencer; writes and reads during clear ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_at(cyc, K_BUSY, 0, 64'd1, "busy_restart");
        rf_a.rf_we[0]   = 1'b1;
        rf_a.rf_dst[0]  = 5'd5;
        rf_a.rf_dstv[0] = 64'h77;
        rf_a.du_stall   = 1'b1;
        rf_a.du_we_rf   = 1'b1;
        rf_a.du_addr    = 12'd3;
        rf_a.du_dato    = 64'h55;
        rf_a.rf_src1[1] = 5'd7;
        for (int k = 1; k <= 32; k++) begin
            step();
            expect_at(cyc, K_BUSY, 0, (k < 32) ? 64'd1 : 64'd0, "busy_restart_seq");
            expect_at(cyc, K_SRCV1, 1, 64'd0, "read_zero_in_clear");
            expect_at(cyc, K_ACK, 0, 64'd0, "dbg_ignored_in_clear");
        end
        idle();
        rf_a.rf_src1[0] = 5'd5;
        rf_a.rf_src2[0] = 5'd3;
        rf_a.rf_src2[1] = 5'd9;
        expect_at(cyc + 1, K_SRCV1, 0, 64'd0, "clear_ignored_wr5");
        expect_at(cyc + 1, K_SRCV2, 0, 64'd0, "clear_ignored_dbg3");
        expect_at(cyc + 1, K_SRCV2, 1, 64'd0, "clear_wiped_r9");
        step();
        idle();

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 20 && sb.size() != 0; w++) step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pu_riscv_rf_mp

// File: doc/pu_riscv_rf_mp.md
PU_RISCV_RF_MP -- requirements
Module: pu_riscv_rf_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, register width in bits.
REQ-002 SHALL have parameter AR_BITS, default 5, address width; depth = 2**AR_BITS entries.
REQ-003 SHALL have parameter RDPORTS, default 2, number of read port pairs (src1/src2).
REQ-004 SHALL have parameter WRPORTS, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled.
REQ-006 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: rf_src1, rf_src2  in  [RDPORTS][AR_BITS]  read addresses.
REQ-008 SHALL have ports: rf_srcv1, rf_srcv2  out  [RDPORTS][XLEN]  read data.
REQ-009 SHALL have ports: rf_dst  in  [WRPORTS][AR_BITS]; rf_dstv  in  [WRPORTS][XLEN]; rf_we  in  [WRPORTS]  write ports.
REQ-010 SHALL have port rf_busy  out  1  high while the clear sequencer runs.
REQ-011 SHALL have debug ports: du_stall  in  1; du_we_rf  in  1; du_re_rf  in  1; du_addr  in  12; du_dato  in  XLEN; du_dati_rf  out  XLEN; du_ack  out  1.

Function
REQ-012 Reads SHALL be registered: address sampled at edge N, data valid on rf_srcv* after edge N (1-cycle latency).
REQ-013 Address 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-014 With BYPASS=1, when a read address sampled at edge N matches a nonzero address written at edge N, rf_srcv* SHALL return the newly written value; with BYPASS=0, the old value.
REQ-015 Multiple write ports to the same address in one cycle: highest-index port SHALL win; bypass SHALL forward that same value.
REQ-016 Clear sequencer states: CLEAR, READY; entered CLEAR on rst; in CLEAR writes zero to entry cnt each cycle, cnt increments, transitions to READY after cnt = 2**AR_BITS-1 is written.
REQ-017 rf_busy SHALL be 1 in CLEAR, 0 in READY; cnt wraps to 0 on exit.
REQ-018 In CLEAR, rf_we and debug writes SHALL be ignored and all read outputs SHALL be zero.
REQ-019 Debug accesses SHALL be honoured only when du_stall=1 and state READY; address = du_addr[AR_BITS-1:0].
REQ-020 Debug write (du_we_rf) SHALL take priority over all rf_we ports in the same cycle; the debug value is the forwarded value.
REQ-021 Debug read (du_re_rf) SHALL return data on du_dati_rf one cycle later with du_ack=1 for exactly one cycle; address 0 returns zero.
REQ-022 du_we_rf and du_re_rf together SHALL perform the write and return the written value (read-after-write order).
REQ-023 du_ack SHALL also pulse one cycle after an accepted debug write; unaccepted requests produce no ack.
REQ-024 du_dati_rf SHALL hold its value until the next accepted debug read.

Reset
REQ-025 rst sampled high SHALL force state CLEAR, cnt=0, rf_busy=1, rf_srcv*=0, du_dati_rf=0, du_ack=0 after that edge.
REQ-026 rst asserted mid-clear SHALL restart the sequencer at cnt=0.
REQ-027 rst asserted mid-operation SHALL drop any in-flight debug ack and read data.
REQ-028 Clear SHALL complete in exactly 2**AR_BITS cycles after rst deasserts.

Structure
REQ-029 Package pu_riscv_rf_pkg SHALL hold the sequencer state enum (CLEAR, READY) and the du_addr width constant (12).
REQ-030 The clear sequencer SHALL be a sub-module pu_riscv_rf_clr (outputs busy, clear address, clear enable).
REQ-031 Storage SHALL be a single array; write-port priority SHALL resolve in one combinational merge before the array.

Verification
REQ-032 Reset: rst 1 cycle, AR_BITS=5 -> rf_busy high exactly 32 cycles, then every address reads 0.
REQ-033 Bypass: write port0 addr 5 = 0xDEAD while src1[0]=5 -> rf_srcv1[0]=0xDEAD next cycle (BYPASS=1), old value 0 (BYPASS=0).
REQ-034 Conflict: port0 and port1 write addr 7 = 0x11 / 0x22 -> later read of 7 returns 0x22.
REQ-035 x0: write addr 0 = 0xFF -> read of 0 returns 0 on both src1 and src2.
REQ-036 Debug: du_stall=1, du_we_rf addr 3 = 0xAB with rf_we[1] addr 3 = 0xCD -> reg3 = 0xAB; du_re_rf addr 3 -> du_dati_rf=0xAB, du_ack one cycle.
REQ-037 Mid-clear reset: rst at cnt=10 -> rf_busy stays high 32 further cycles; writes during clear ignored.
